memory_arbiter: RTL and testbench

Arbitrates the processor's instruction-fetch and data-access requests onto the single-ported RAM. Sits between the datapath's request signals (iREN, dREN/dWEN, from control decode) and the RAM model. It latches one request at a time, sequences it through the RAM handshake and returns the data with a one-cycle wait release. It alternates grants fairly when both ports are requesting. A sticky fault state is entered on RAM error or timeout.

---
 rtl/memory_arbiter.sv | 156 +++++++++++++++
 tb/tb_memory_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: grants instruction-fetch and data-access requests one at a
// time onto a single-ported RAM and alternates grants when both ports request.
// A RAM error or an access that never reaches ACCESS within TIMEOUT cycles
// enters a sticky fault state that only RST clears.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, IREQ, DREQ, IRESP, DRESP, FAULT} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_state_t;

  state_t            state, state_next;
  grant_t            last_grant;
  logic [WORD_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_store;
  logic              lat_write;
  logic [CNT_W-1:0]  cnt;

  logic dreq;
  logic grant_i;
  logic grant_d;
  logic ram_access;
  logic ram_error;
  logic timed_out;

  // Request decode and fair arbitration: on contention the port not served last wins.
  always_comb begin
    dreq       = dREN | dWEN;
    grant_i    = iREN & (~dreq | (last_grant == GRANT_D));
    grant_d    = dreq & (~iREN | (last_grant == GRANT_I));
    ram_access = (ramstate == RAM_ACCESS);
    ram_error  = (ramstate == RAM_ERROR);
    timed_out  = (cnt == CNT_W'(TIMEOUT - 1));
  end

  // State register, request latches, timeout counter and returned data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      lat_addr   <= '0;
      lat_store  <= '0;
      lat_write  <= 1'b0;
      cnt        <= '0;
      iload      <= '0;
      dload      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant_i) begin
            lat_addr   <= iaddr;
            lat_store  <= '0;
            lat_write  <= 1'b0;
            cnt        <= '0;
            last_grant <= GRANT_I;
          end else if (grant_d) begin
            lat_addr   <= daddr;
            lat_store  <= dstore;
            lat_write  <= dWEN;
            cnt        <= '0;
            last_grant <= GRANT_D;
          end
        end
        IREQ: begin
          if (ram_access) begin
            iload <= ramload;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DREQ: begin
          if (ram_access) begin
            if (!lat_write) begin
              dload <= ramload;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and state-derived RAM strobes / fault flag.
  always_comb begin
    state_next = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    mem_err    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_i) begin
          state_next = IREQ;
        end else if (grant_d) begin
          state_next = DREQ;
        end
      end
      IREQ: begin
        ramREN = 1'b1;
        if (ram_access) begin
          state_next = IRESP;
        end else if (ram_error || timed_out) begin
          state_next = FAULT;
        end
      end
      DREQ: begin
        ramREN = ~lat_write;
        ramWEN = lat_write;
        if (ram_access) begin
          state_next = DRESP;
        end else if (ram_error || timed_out) begin
          state_next = FAULT;
        end
      end
      IRESP:   state_next = IDLE;
      DRESP:   state_next = IDLE;
      FAULT:   mem_err = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  // Wait lines follow the request and drop only during the matching response cycle.
  always_comb begin
    iwait    = iREN & (state != IRESP);
    dwait    = dreq & (state != DRESP);
    ramaddr  = lat_addr;
    ramstore = lat_store;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a transaction-level model plus a
// simple RAM responder, with directed scenarios and literal spot checks.
module tb_memory_arbiter;

  localparam int unsigned TO = 15;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = 2'd0;
  logic        mem_err;

  memory_arbiter #(.TIMEOUT(TO), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM responder: BUSY for ram_busy strobe cycles then ACCESS, or stuck/error modes.
  int          ram_busy = 0;
  int          ram_mode = 0;   // 0 normal, 1 stuck BUSY, 2 ERROR
  bit          ram_fixed_en = 1'b0;
  logic [31:0] ram_fixed = '0;
  int          sc = 0;
  always @(posedge CLK) begin
    #1;
    if (ramREN || ramWEN) begin
      if (ram_mode == 1)      ramstate = 2'd1;
      else if (ram_mode == 2) ramstate = 2'd3;
      else                    ramstate = (sc < ram_busy) ? 2'd1 : 2'd2;
      sc++;
      ramload = ram_fixed_en ? ram_fixed : (ramaddr ^ 32'h5A5A_0000);
    end else begin
      sc = 0;
      ramstate = 2'd0;
    end
  end

  // Transaction model: phase 0 = nothing in flight, 1 = access on RAM, 2 = reply cycle.
  int          m_phase = 0;
  bit          m_fault = 1'b0;
  bit          m_is_i = 1'b0;
  bit          m_last_i = 1'b0;
  bit          m_wr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_store = '0;
  logic [31:0] m_iload = '0;
  logic [31:0] m_dload = '0;
  int          m_nacc = 0;
  always @(posedge CLK) begin
    if (RST) begin
      m_phase = 0; m_fault = 1'b0; m_last_i = 1'b0;
      m_iload = '0; m_dload = '0; m_nacc = 0;
    end else if (!m_fault) begin
      case (m_phase)
        0: begin
          if (iREN || dREN || dWEN) begin
            m_is_i   = iREN && (!(dREN || dWEN) || !m_last_i);
            m_last_i = m_is_i;
            m_addr   = m_is_i ? iaddr : daddr;
            m_store  = dstore;
            m_wr     = !m_is_i && dWEN;
            m_nacc   = 0;
            m_phase  = 1;
          end
        end
        1: begin
          if (ramstate == 2'd2) begin
            if (m_is_i) m_iload = ramload;
            else if (!m_wr) m_dload = ramload;
            m_phase = 2;
          end else if (ramstate == 2'd3) begin
            m_fault = 1'b1;
          end else begin
            m_nacc++;
            if (m_nacc == TO) m_fault = 1'b1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      logic e_ren, e_wen, e_iw, e_dw;
      e_ren = (m_phase == 1) && !m_fault && (m_is_i || !m_wr);
      e_wen = (m_phase == 1) && !m_fault && !m_is_i && m_wr;
      e_iw  = iREN && !(m_phase == 2 && m_is_i);
      e_dw  = (dREN || dWEN) && !(m_phase == 2 && !m_is_i);
      chk("m_ramREN", {31'd0, ramREN}, {31'd0, e_ren});
      chk("m_ramWEN", {31'd0, ramWEN}, {31'd0, e_wen});
      chk("m_iwait", {31'd0, iwait}, {31'd0, e_iw});
      chk("m_dwait", {31'd0, dwait}, {31'd0, e_dw});
      chk("m_mem_err", {31'd0, mem_err}, {31'd0, m_fault});
      chk("m_iload", iload, m_iload);
      chk("m_dload", dload, m_dload);
      if (e_ren || e_wen) chk("m_ramaddr", ramaddr, m_addr);
      if (e_wen) chk("m_ramstore", ramstore, m_store);
    end
  end

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
  endtask

  logic [31:0] order_q[$];
  int          ilow, dlow, strobes;

  initial begin
    repeat (2) @(posedge CLK);
    cyc();
    RST = 1'b0;
    chk_en = 1'b1;

    // Reset values
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);

    // Instruction fetch, zero-wait RAM
    ram_fixed_en = 1'b1; ram_fixed = 32'h2408_000A;
    iREN = 1'b1; iaddr = 32'h40;
    cyc();
    chk("t1_ramREN_c1", {31'd0, ramREN}, 32'd1);
    chk("t1_ramaddr_c1", ramaddr, 32'h40);
    chk("t1_iwait_c1", {31'd0, iwait}, 32'd1);
    cyc();
    chk("t1_iwait_c2", {31'd0, iwait}, 32'd0);
    chk("t1_iload", iload, 32'h2408_000A);
    iREN = 1'b0; ram_fixed_en = 1'b0;
    cyc();

    // Data write with 3 BUSY cycles; daddr changed mid-access
    ram_busy = 3;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 1) daddr = 32'h200;
      chk("t2_ramWEN", {31'd0, ramWEN}, 32'd1);
      chk("t2_ramaddr", ramaddr, 32'h100);
      chk("t2_ramstore", ramstore, 32'hDEAD_BEEF);
      chk("t2_dwait", {31'd0, dwait}, 32'd1);
    end
    cyc();
    chk("t2_dwait_c5", {31'd0, dwait}, 32'd0);
    chk("t2_dload_kept", dload, 32'd0);
    dWEN = 1'b0;
    cyc();

    // Data read, 1 BUSY cycle
    ram_busy = 1;
    dREN = 1'b1; daddr = 32'h200;
    cyc(); cyc(); cyc();
    chk("t3_dwait", {31'd0, dwait}, 32'd0);
    chk("t3_dload", dload, 32'h5A5A_0200);
    dREN = 1'b0;
    cyc();

    // Sustained contention from reset: I,D,I,D
    do_reset();
    ram_busy = 0;
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h300;
    ilow = 0; dlow = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (ramREN || ramWEN) order_q.push_back(ramaddr);
      if (!iwait) ilow++;
      if (!dwait) dlow++;
    end
    iREN = 1'b0; dREN = 1'b0;
    chk("t4_grants", order_q.size(), 32'd4);
    if (order_q.size() == 4) begin
      chk("t4_g0", order_q[0], 32'h80);
      chk("t4_g1", order_q[1], 32'h300);
      chk("t4_g2", order_q[2], 32'h80);
      chk("t4_g3", order_q[3], 32'h300);
    end
    chk("t4_irel", ilow, 32'd2);
    chk("t4_drel", dlow, 32'd2);
    cyc();

    // Dropped request mid-access still completes
    ram_busy = 2;
    iREN = 1'b1; iaddr = 32'h4C;
    cyc();
    iREN = 1'b0;
    cyc(); cyc(); cyc();
    chk("t5_iload", iload, 32'h5A5A_004C);
    cyc();

    // Timeout fault
    ram_mode = 1;
    iREN = 1'b1; iaddr = 32'h44;
    strobes = 0;
    for (int i = 0; i < 40 && !mem_err; i++) begin
      cyc();
      if (ramREN) strobes++;
    end
    chk("t6_strobes", strobes, 32'd15);
    chk("t6_mem_err", {31'd0, mem_err}, 32'd1);
    chk("t6_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t6_iwait", {31'd0, iwait}, 32'd1);
    iREN = 1'b0; dREN = 1'b1;
    cyc(); cyc();
    chk("t6_dwait", {31'd0, dwait}, 32'd1);
    chk("t6_sticky", {31'd0, mem_err}, 32'd1);
    dREN = 1'b0;
    do_reset();
    chk("t6_clr", {31'd0, mem_err}, 32'd0);
    ram_mode = 0;
    cyc();

    // RAM error fault
    ram_mode = 2;
    dREN = 1'b1; daddr = 32'h10;
    cyc(); cyc();
    chk("t7_mem_err", {31'd0, mem_err}, 32'd1);
    dREN = 1'b0;
    do_reset();
    ram_mode = 0;
    cyc();

    // Reset during DREQ with BUSY RAM, then a normal fetch
    ram_busy = 10;
    dWEN = 1'b1; daddr = 32'h120; dstore = 32'h1234_5678;
    cyc(); cyc();
    RST = 1'b1;
    cyc();
    chk("t8_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("t8_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t8_dwait", {31'd0, dwait}, 32'd1);
    RST = 1'b0; dWEN = 1'b0;
    cyc();
    ram_busy = 0;
    iREN = 1'b1; iaddr = 32'h48;
    cyc();
    chk("t8_ireq", {31'd0, ramREN}, 32'd1);
    cyc();
    chk("t8_iwait", {31'd0, iwait}, 32'd0);
    chk("t8_iload", iload, 32'h5A5A_0048);
    iREN = 1'b0;
    cyc(); cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
